// File: rtl/ro_odometer_pkg.sv
// Shared encodings for the RO lifecycle odometer: decoder mode codes and the
// measurement sequencer state enum.
package ro_odometer_pkg;

  localparam logic [1:0] MODE_CLR    = 2'b00;
  localparam logic [1:0] MODE_STRESS = 2'b01;
  localparam logic [1:0] MODE_MEAS   = 2'b10;
  localparam logic [1:0] MODE_IDLE   = 2'b11;

  // Wide enough for both the clear hold and the measure timeout count.
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_REPORT  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/ro_diff_calc.sv
// Aging difference between reference and stressed RO counts, floored at zero,
// plus the recycled-die threshold compare.
module ro_diff_calc #(
  parameter logic [31:0] DIFF_THRESH = 32'd16
) (
  input  logic [31:0] r_freq,
  input  logic [31:0] s_freq,
  output logic [31:0] diff,
  output logic        over_thresh
);

  always_comb begin
    diff        = (s_freq > r_freq) ? 32'd0 : (r_freq - s_freq);
    over_thresh = (diff >= DIFF_THRESH);
  end

endmodule

// File: rtl/ro_odometer_ctrl.sv
// Sweep sequencer for the RO lifecycle odometer: clear, measure and report each
// reference/stressed pair, parking the decoder in stress mode between sweeps.
module ro_odometer_ctrl
  import ro_odometer_pkg::*;
#(
  parameter int          NO_CDIR      = 8,
  parameter int          MUX_SEL_SIZE = 3,
  parameter int          CLR_CYC      = 4,
  parameter int          MEAS_TIMEOUT = 1023,
  parameter logic [31:0] DIFF_THRESH  = 32'd16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic [1:0]              mode,
  output logic [MUX_SEL_SIZE-1:0] r_mux_sel,
  output logic [MUX_SEL_SIZE-1:0] s_mux_sel,
  input  logic [31:0]             r_freq,
  input  logic [31:0]             s_freq,
  input  logic                    meas_valid,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [MUX_SEL_SIZE-1:0] res_idx,
  output logic [31:0]             res_diff,
  output logic                    res_recycled,
  output logic                    res_timeout,
  output logic                    sweep_done,
  output logic                    recycled_any,
  output state_e                  dbg_state
);

  localparam logic [CNT_W-1:0]        CLR_LAST  = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0]        MEAS_LAST = CNT_W'(MEAS_TIMEOUT - 1);
  localparam logic [MUX_SEL_SIZE-1:0] IDX_LAST  = MUX_SEL_SIZE'(NO_CDIR - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MUX_SEL_SIZE-1:0] idx_q, idx_d;
  logic [1:0]              mode_q, mode_d;
  logic                    busy_q, busy_d;
  logic                    res_valid_q, res_valid_d;
  logic [MUX_SEL_SIZE-1:0] res_idx_q, res_idx_d;
  logic [31:0]             res_diff_q, res_diff_d;
  logic                    res_recycled_q, res_recycled_d;
  logic                    res_timeout_q, res_timeout_d;
  logic                    sweep_done_q, sweep_done_d;
  logic                    recycled_any_q, recycled_any_d;

  logic [31:0] calc_diff;
  logic        calc_over;

  ro_diff_calc #(.DIFF_THRESH(DIFF_THRESH)) u_diff (
    .r_freq      (r_freq),
    .s_freq      (s_freq),
    .diff        (calc_diff),
    .over_thresh (calc_over)
  );

  // Result handshake: res_valid rises on the first REPORT cycle and the res_*
  // fields hold until res_valid && res_ready; the beat is consumed on that edge.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    res_valid_d    = res_valid_q;
    res_idx_d      = res_idx_q;
    res_diff_d     = res_diff_q;
    res_recycled_d = res_recycled_q;
    res_timeout_d  = res_timeout_q;
    recycled_any_d = recycled_any_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_CLEAR;
          idx_d          = '0;
          cnt_d          = '0;
          recycled_any_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (meas_valid) begin
          state_d        = ST_REPORT;
          res_valid_d    = 1'b1;
          res_idx_d      = idx_q;
          res_diff_d     = calc_diff;
          res_recycled_d = calc_over;
          res_timeout_d  = 1'b0;
        end else if (cnt_q == MEAS_LAST) begin
          // Decoder never answered: report an invalid, non-recycled result.
          state_d        = ST_REPORT;
          res_valid_d    = 1'b1;
          res_idx_d      = idx_q;
          res_diff_d     = 32'd0;
          res_recycled_d = 1'b0;
          res_timeout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          res_valid_d    = 1'b0;
          recycled_any_d = recycled_any_q | res_recycled_q;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CLEAR;
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_CLEAR:   mode_d = MODE_CLR;
      ST_MEASURE: mode_d = MODE_MEAS;
      default:    mode_d = MODE_STRESS;
    endcase
    busy_d       = (state_d != ST_IDLE);
    sweep_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      mode_q         <= MODE_STRESS;
      busy_q         <= 1'b0;
      res_valid_q    <= 1'b0;
      res_idx_q      <= '0;
      res_diff_q     <= 32'd0;
      res_recycled_q <= 1'b0;
      res_timeout_q  <= 1'b0;
      sweep_done_q   <= 1'b0;
      recycled_any_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      mode_q         <= mode_d;
      busy_q         <= busy_d;
      res_valid_q    <= res_valid_d;
      res_idx_q      <= res_idx_d;
      res_diff_q     <= res_diff_d;
      res_recycled_q <= res_recycled_d;
      res_timeout_q  <= res_timeout_d;
      sweep_done_q   <= sweep_done_d;
      recycled_any_q <= recycled_any_d;
    end
  end

  assign busy         = busy_q;
  assign mode         = mode_q;
  assign r_mux_sel    = idx_q;
  assign s_mux_sel    = idx_q;
  assign res_valid    = res_valid_q;
  assign res_idx      = res_idx_q;
  assign res_diff     = res_diff_q;
  assign res_recycled = res_recycled_q;
  assign res_timeout  = res_timeout_q;
  assign sweep_done   = sweep_done_q;
  assign recycled_any = recycled_any_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ro_odometer_ctrl.sv
// Directed bench for ro_odometer_ctrl with a behavioural decoder that answers a
// fixed number of cycles into each measurement.
module tb_ro_odometer_ctrl;
  import ro_odometer_pkg::*;

  localparam int NO_CDIR      = 8;
  localparam int CLR_CYC      = 4;
  localparam int MEAS_TIMEOUT = 1023;
  localparam int DEC_LAT      = 3;   // decoder answers on its 3rd MEASURE cycle
  localparam int LAT_EXP      = 7;   // CLR_CYC + k + 1 with k = 2
  localparam int W            = 43;  // {r_sel, s_sel, idx, diff, recycled, timeout}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [1:0]  mode;
  logic [2:0]  r_mux_sel, s_mux_sel, res_idx;
  logic [31:0] r_freq = 32'd0, s_freq = 32'd0, res_diff;
  logic        meas_valid = 1'b0;
  logic        res_valid, res_ready = 1'b0;
  logic        res_recycled, res_timeout, sweep_done, recycled_any;
  state_e      dbg_state;

  logic [31:0] r_tab [NO_CDIR];
  logic [31:0] s_tab [NO_CDIR];
  logic [7:0]  withhold = 8'h00;
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  ro_odometer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .mode(mode),
    .r_mux_sel(r_mux_sel), .s_mux_sel(s_mux_sel), .r_freq(r_freq), .s_freq(s_freq),
    .meas_valid(meas_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .res_diff(res_diff), .res_recycled(res_recycled),
    .res_timeout(res_timeout), .sweep_done(sweep_done), .recycled_any(recycled_any),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // decoder model
  initial begin
    int meas_cnt;
    meas_cnt = 0;
    forever begin
      @(negedge clk);
      if (mode == MODE_MEAS) begin
        meas_cnt++;
        if (meas_cnt == DEC_LAT && !withhold[r_mux_sel]) begin
          meas_valid = 1'b1;
          r_freq     = r_tab[r_mux_sel];
          s_freq     = s_tab[r_mux_sel];
        end else begin
          meas_valid = 1'b0;
        end
      end else begin
        meas_cnt   = 0;
        meas_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sweep_done === 1'b1) done_cnt++;
    end
  end

  function automatic logic [W-1:0] mk(input int i, input logic [31:0] d,
                                      input logic rec, input logic to);
    logic [2:0] s3;
    s3 = 3'(i);
    return {s3, s3, s3, d, rec, to};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("rsel=%0d ssel=%0d idx=%0d diff=0x%0h rec=%0b to=%0b",
                     v[42:40], v[39:37], v[36:34], v[33:2], v[1], v[0]);
  endfunction

  // driver tasks
  task automatic set_tables(input logic [31:0] r, input logic [31:0] s);
    for (int i = 0; i < NO_CDIR; i++) begin
      r_tab[i] = r;
      s_tab[i] = s;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(output logic [W-1:0] got, output bit ok);
    ok  = 1'b0;
    got = '0;
    for (int c = 0; c < 200 && res_valid !== 1'b1; c++) @(negedge clk);
    if (res_valid === 1'b1) begin
      ok  = 1'b1;
      got = {r_mux_sel, s_mux_sel, res_idx, res_diff, res_recycled, res_timeout};
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mode, busy, res_valid, sweep_done, recycled_any, res_recycled, res_timeout} !== 8'b01_000000) begin
      errors++;
      $display("FAIL reset_ctrl: mode=%b busy=%b vld=%b done=%b rany=%b rec=%b to=%b, expected mode=01 rest 0",
               mode, busy, res_valid, sweep_done, recycled_any, res_recycled, res_timeout);
    end
    checks++;
    if ({r_mux_sel, s_mux_sel, res_idx, res_diff} !== 41'd0) begin
      errors++;
      $display("FAIL reset_data: rsel=%0d ssel=%0d idx=%0d diff=0x%0h, expected all 0",
               r_mux_sel, s_mux_sel, res_idx, res_diff);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d, expected %0d", dbg_state, ST_IDLE);
    end
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (mode !== MODE_STRESS || busy !== 1'b0 || res_valid !== 1'b0 || sweep_done !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_idle50: activity seen while idle, expected mode=01 busy=0 vld=0 done=0");
    end
  endtask

  task automatic test_nominal();
    logic [W-1:0] got, exp;
    bit ok;
    int lat;
    set_tables(32'h200, 32'h1F8);
    withhold = 8'h00; res_ready = 1'b1; done_cnt = 0;
    for (int i = 0; i < NO_CDIR; i++) exp_q.push_back(mk(i, 32'd8, 1'b0, 1'b0));
    pulse_start();
    checks++;
    if (mode !== MODE_CLR || busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_enter: mode=%b busy=%b, expected mode=00 busy=1", mode, busy);
    end
    lat = 0;
    while (res_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != LAT_EXP) begin
      errors++;
      $display("FAIL nominal_latency: %0d cycles, expected %0d", lat, LAT_EXP);
    end
    for (int i = 0; i < NO_CDIR; i++) begin
      collect(got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL nominal_res[%0d]: ok=%0b %s, expected %s", i, ok, fmt(got), fmt(exp));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1 || recycled_any !== 1'b0 || busy !== 1'b0 || mode !== MODE_STRESS) begin
      errors++;
      $display("FAIL nominal_end: done_pulses=%0d rany=%b busy=%b mode=%b, expected 1 0 0 01",
               done_cnt, recycled_any, busy, mode);
    end
  endtask

  task automatic test_recycled();
    logic [W-1:0] got, exp;
    bit ok;
    set_tables(32'h200, 32'h1F8);
    s_tab[5] = 32'h1D0;
    withhold = 8'h00; res_ready = 1'b1; done_cnt = 0;
    for (int i = 0; i < NO_CDIR; i++)
      exp_q.push_back((i == 5) ? mk(i, 32'h30, 1'b1, 1'b0) : mk(i, 32'd8, 1'b0, 1'b0));
    pulse_start();
    for (int i = 0; i < NO_CDIR; i++) begin
      collect(got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL recycled_res[%0d]: ok=%0b %s, expected %s", i, ok, fmt(got), fmt(exp));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (recycled_any !== 1'b1 || done_cnt != 1) begin
      errors++;
      $display("FAIL recycled_any_hold: rany=%b done_pulses=%0d, expected 1 and 1", recycled_any, done_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] got, exp;
    logic [31:0] s_vec [NO_CDIR];
    logic [31:0] d_vec [NO_CDIR];
    logic [7:0]  rec_vec;
    bit ok;
    s_vec = '{32'h200, 32'h1F8, 32'h1F0, 32'h300, 32'h1F1, 32'h000, 32'h201, 32'h000};
    d_vec = '{32'd0, 32'd8, 32'd16, 32'd0, 32'd15, 32'h200, 32'd0, 32'hFFFF_FFFF};
    rec_vec = 8'b1010_0100;
    set_tables(32'h200, 32'h0);
    for (int i = 0; i < NO_CDIR; i++) s_tab[i] = s_vec[i];
    r_tab[7] = 32'hFFFF_FFFF;
    withhold = 8'h00; res_ready = 1'b1; done_cnt = 0;
    for (int i = 0; i < NO_CDIR; i++) exp_q.push_back(mk(i, d_vec[i], rec_vec[i], 1'b0));
    pulse_start();
    checks++;
    if (recycled_any !== 1'b0) begin
      errors++;
      $display("FAIL rany_clear_on_start: rany=%b, expected 0", recycled_any);
    end
    for (int i = 0; i < NO_CDIR; i++) begin
      collect(got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL sat_res[%0d]: ok=%0b %s, expected %s", i, ok, fmt(got), fmt(exp));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (recycled_any !== 1'b1 || done_cnt != 1) begin
      errors++;
      $display("FAIL sat_end: rany=%b done_pulses=%0d, expected 1 and 1", recycled_any, done_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] got, exp;
    bit ok;
    int m_cnt;
    set_tables(32'h200, 32'h1F8);
    s_tab[2] = 32'h100;
    withhold = 8'b0000_0100; res_ready = 1'b1; done_cnt = 0;
    for (int i = 0; i < NO_CDIR; i++)
      exp_q.push_back((i == 2) ? mk(i, 32'd0, 1'b0, 1'b1) : mk(i, 32'd8, 1'b0, 1'b0));
    pulse_start();
    checks++;
    if (recycled_any !== 1'b0) begin
      errors++;
      $display("FAIL rany_clear_on_start2: rany=%b, expected 0", recycled_any);
    end
    for (int i = 0; i < NO_CDIR; i++) begin
      if (i == 2) begin
        for (int c = 0; c < 50 && mode !== MODE_MEAS; c++) @(negedge clk);
        m_cnt = 0;
        while (res_valid !== 1'b1 && m_cnt < 3000) begin
          @(negedge clk);
          m_cnt++;
        end
        checks++;
        if (m_cnt != MEAS_TIMEOUT) begin
          errors++;
          $display("FAIL timeout_latency: %0d cycles after MEASURE entry, expected %0d", m_cnt, MEAS_TIMEOUT);
        end
      end
      collect(got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL timeout_res[%0d]: ok=%0b %s, expected %s", i, ok, fmt(got), fmt(exp));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (recycled_any !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL timeout_end: rany=%b done_pulses=%0d, expected 0 and 1", recycled_any, done_cnt);
    end
    withhold = 8'h00;
  endtask

  task automatic test_stall_reset();
    logic [W-1:0] got, exp;
    bit bad;
    set_tables(32'h200, 32'h1F8);
    s_tab[0] = 32'h1D0;
    withhold = 8'h00; res_ready = 1'b0; done_cnt = 0;
    pulse_start();
    for (int c = 0; c < 100 && res_valid !== 1'b1; c++) @(negedge clk);
    exp = mk(0, 32'h30, 1'b1, 1'b0);
    bad = 1'b0;
    got = '0;
    for (int c = 0; c < 20; c++) begin
      got = {r_mux_sel, s_mux_sel, res_idx, res_diff, res_recycled, res_timeout};
      if (res_valid !== 1'b1 || got !== exp || busy !== 1'b1 || mode !== MODE_STRESS) bad = 1'b1;
      start = (c == 5);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold: last %s vld=%b mode=%b, expected %s vld=1 mode=01", fmt(got), res_valid, mode, fmt(exp));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || r_mux_sel !== 3'd1 || mode !== MODE_CLR || recycled_any !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept: vld=%b rsel=%0d mode=%b rany=%b, expected 0 1 00 1",
               res_valid, r_mux_sel, mode, recycled_any);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== MODE_STRESS || busy !== 1'b0 || res_valid !== 1'b0 || r_mux_sel !== 3'd0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL async_reset: mode=%b busy=%b vld=%b rsel=%0d state=%0d, expected 01 0 0 0 IDLE",
               mode, busy, res_valid, r_mux_sel, dbg_state);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0 || recycled_any !== 1'b0 || mode !== MODE_STRESS) begin
      errors++;
      $display("FAIL post_reset: done_pulses=%0d busy=%b rany=%b mode=%b, expected 0 0 0 01",
               done_cnt, busy, recycled_any, mode);
    end
  endtask

  initial begin
    set_tables(32'h0, 32'h0);
    test_reset();
    test_nominal();
    test_recycled();
    test_saturation();
    test_timeout();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_odometer_ctrl.md
Name: ro_odometer_ctrl

Overview:
- Measurement sequencer that drives the control side of the sn_cdir_decoder lifecycle odometer and consumes its frequency outputs.
- On a start request it sweeps all NO_CDIR reference/stressed RO pairs in turn: clear, measure, capture, compute the aging difference, flag recycled dies.
- Each per-sensor result goes to the host over a valid/ready handshake.
- Between sweeps it parks the odometer in stress mode, so the stressed ROs keep aging.

Parameters:
- NO_CDIR, 8, number of RO pairs / CDIR sensors swept.
- MUX_SEL_SIZE, 3, select width; equals log2(NO_CDIR).
- CLR_CYC, 4, cycles mode=00 is held before each measurement (1..255).
- MEAS_TIMEOUT, 1023, maximum cycles spent waiting for meas_valid in MEASURE (must exceed decoder TIMER plus margin).
- DIFF_THRESH, 32'd16, aging threshold; a difference at or above this sets the recycled flag.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle sweep request; sampled only in IDLE.
- busy, output, 1, high in every state except IDLE.
- mode, output, 2, to decoder: 00 clear, 01 stress, 10 measure, 11 idle.
- r_mux_sel, output, MUX_SEL_SIZE, reference RO select to decoder.
- s_mux_sel, output, MUX_SEL_SIZE, stressed RO select to decoder.
- r_freq, input, 32, reference RO count from decoder.
- s_freq, input, 32, stressed RO count from decoder.
- meas_valid, input, 1, decoder valid_out.
- res_valid, output, 1, result available.
- res_ready, input, 1, host accepts the result.
- res_idx, output, MUX_SEL_SIZE, sensor index of the result.
- res_diff, output, 32, aging difference.
- res_recycled, output, 1, res_diff >= DIFF_THRESH.
- res_timeout, output, 1, measurement timed out; diff is invalid.
- sweep_done, output, 1, one-cycle pulse after the last result is accepted.
- recycled_any, output, 1, sticky OR of res_recycled over the current sweep.

Behaviour:
- Reset (async, rst_n=0), all registered:
  - state=IDLE, mode=01, both mux selects=0, counters=0.
  - res_valid=0, res_idx=0, res_diff=0, res_recycled=0, res_timeout=0.
  - sweep_done=0, recycled_any=0, busy=0.
- Reset mid-sweep aborts immediately. No partial result is kept and no sweep_done is issued.
- States and transitions:
  - IDLE: mode=01. If start=1, then next cycle: idx=0, recycled_any cleared, go to CLEAR.
  - CLEAR: mode=00 for exactly CLR_CYC cycles, then MEASURE. Cycle counter reloads on entry.
  - MEASURE: mode=10; timeout counter starts at 0.
    - If meas_valid=1: latch r_freq and s_freq that cycle, go to REPORT.
    - Else if the counter reaches MEAS_TIMEOUT: go to REPORT with the timeout flag set.
    - meas_valid outside MEASURE is ignored.
  - REPORT: mode=01; res_valid=1 starting on the first REPORT cycle.
    - res_* fields are stable while res_valid=1 and res_ready=0.
    - On res_valid & res_ready: res_valid drops the next cycle. If idx==NO_CDIR-1 go to DONE, else idx+1 and go to CLEAR.
  - DONE: sweep_done=1 for one cycle, then IDLE.
- Mux: r_mux_sel = s_mux_sel = idx, constant from CLEAR through REPORT of that index.
- Arithmetic:
  - res_diff = r_freq - s_freq, 32-bit unsigned, saturating to 0 when s_freq > r_freq.
  - res_recycled = !res_timeout && (res_diff >= DIFF_THRESH).
  - On timeout: res_diff=0, res_recycled=0, res_timeout=1.
- recycled_any:
  - Set when a result with res_recycled=1 is accepted.
  - Holds after the sweep; cleared at the next start.
- start while busy is ignored (no queueing).
- Index wrap: idx never exceeds NO_CDIR-1; the sweep ends after that index.
- Latency per sensor, from CLEAR entry to res_valid:
  - CLR_CYC + k + 1 cycles, where k is the number of MEASURE cycles before meas_valid (at least 1).
  - Plus host stall cycles before res_ready.

Decomposition:
- Package ro_odometer_pkg:
  - mode encodings MODE_CLR=2'b00, MODE_STRESS=2'b01, MODE_MEAS=2'b10, MODE_IDLE=2'b11;
  - FSM state enum.
  - Shared with the decoder and benches.
- Sub-module ro_diff_calc (combinational saturating subtract plus threshold compare) is natural.
- The FSM, counters and handshake stay in ro_odometer_ctrl.

Test Plan:
- Reset, then idle 50 cycles -> mode=01, busy=0, res_valid=0, no sweep_done.
- Start; bench decoder model returns r=0x200, s=0x1F8 for all 8 sensors, res_ready tied 1 -> 8 results, res_idx 0..7, res_diff=8, res_recycled=0, one sweep_done, recycled_any=0.
- Sensor 5 returns r=0x200, s=0x1D0 -> idx 5 res_diff=0x30, res_recycled=1; recycled_any=1 after the sweep and cleared by the next start.
- s_freq=0x300 > r_freq=0x200 -> res_diff=0, res_recycled=0 (saturation).
- meas_valid withheld for sensor 2 -> res_timeout=1 exactly MEAS_TIMEOUT cycles after MEASURE entry; res_diff=0; sweep continues to idx 3.
- res_ready held 0 for 20 cycles with an extra start pulse; then rst_n=0 mid-CLEAR -> fields stable and start ignored while stalled; reset gives IDLE, mode=01, no sweep_done.
